// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared types and constants for the load/store unit: address/register
// types, access-size encoding, the default I/O port address, FSM state
// encoding, load-pipeline stage record and small size/mask helpers.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [63:0] reg_t;

    typedef enum logic [1:0] {
        BMD_8  = 2'd0,
        BMD_16 = 2'd1,
        BMD_32 = 2'd2,
        BMD_64 = 2'd3
    } bmd_t;

    localparam addr_t IO_FILE_POINTER_DEFAULT = 32'hfffff000;

    typedef enum logic {
        IDLE    = 1'b0,
        IN_WAIT = 1'b1
    } lsu_state_t;

    // One entry per load-pipeline stage: enough to align the returning word.
    typedef struct packed {
        logic       valid;
        logic [2:0] pos;
        bmd_t       bmd;
    } ld_stage_t;

    // Access size in bytes (1, 2, 4 or 8).
    function automatic logic [3:0] bmd_size(input bmd_t b);
        case (b)
            BMD_8:   return 4'd1;
            BMD_16:  return 4'd2;
            BMD_32:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Byte-enable pattern of an access that starts at lane 0.
    function automatic logic [7:0] bmd_byte_mask(input bmd_t b);
        case (b)
            BMD_8:   return 8'h01;
            BMD_16:  return 8'h03;
            BMD_32:  return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Bit mask used to zero-extend a right-aligned load result.
    function automatic reg_t bmd_data_mask(input bmd_t b);
        case (b)
            BMD_8:   return 64'h0000_0000_0000_00ff;
            BMD_16:  return 64'h0000_0000_0000_ffff;
            BMD_32:  return 64'h0000_0000_ffff_ffff;
            default: return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_out_fifo.sv
// ---------------------------------------------------------------------------
// lsu_out_fifo
// Small synchronous FIFO holding output-port bytes until the consumer
// acknowledges them. DEPTH must be a power of two and at least 2.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   push, push_data  write one entry (ignored while full)
//   pop              drop the head entry (ignored while empty)
//   head             current head entry
//   empty, full      occupancy flags
// ---------------------------------------------------------------------------
module lsu_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] storage [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = storage[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: entries are only visible after being written.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns execute-stage load/store requests into 8-byte-lane memory accesses,
// or into byte transfers on a simple I/O port when the address equals
// IO_FILE_POINTER.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   req_valid/we/addr/bmd/st_data    request from execute; req_ready accepts
//   mem_addr/mem_we/mem_st_data      aligned memory address, byte enables, data
//   mem_ld_data                      memory read data, LOAD_LATENCY cycles later
//   ld_valid, ld_data                load result strobe, zero-extended data
//   misalign_err                     pulse after an access crossing 8 bytes
//   out_req/out_data/out_ack         output-byte handshake (FIFO head)
//   in_valid/in_data/in_ack          input-byte handshake for I/O loads
//
// LOAD_LATENCY must be within 1..4, OUT_FIFO_DEPTH a power of two >= 2.
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int    LOAD_LATENCY    = 1,
    parameter addr_t IO_FILE_POINTER = IO_FILE_POINTER_DEFAULT,
    parameter int    OUT_FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  addr_t       req_addr,
    input  bmd_t        req_bmd,
    input  reg_t        req_st_data,
    output logic        req_ready,
    output addr_t       mem_addr,
    output logic [7:0]  mem_we,
    output reg_t        mem_st_data,
    input  reg_t        mem_ld_data,
    output logic        ld_valid,
    output reg_t        ld_data,
    output logic        misalign_err,
    output logic        out_req,
    output logic [7:0]  out_data,
    input  logic        out_ack,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ack
);

    logic [2:0]  pos;
    logic        is_io;
    logic        accept;
    logic        crosses;
    logic [15:0] we_span;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    ld_stage_t   pipe [LOAD_LATENCY];
    ld_stage_t   tail;
    logic        pipe_busy;
    reg_t        ld_extract;
    lsu_state_t  state;
    logic        io_ld_valid;
    logic [7:0]  io_ld_data;

    assign pos   = req_addr[2:0];
    assign is_io = (req_addr == IO_FILE_POINTER);

    // An I/O load must not race in-flight memory loads for the ld_* outputs.
    assign req_ready = !((state == IN_WAIT) || fifo_full || (is_io && !req_we && pipe_busy));
    assign accept    = req_valid && req_ready;

    assign mem_addr    = {req_addr[31:3], 3'b000};
    assign mem_st_data = req_st_data << {pos, 3'b000};

    // Bytes that would land beyond lane 7 fall into we_span[15:8] and are dropped.
    assign we_span = {8'h00, bmd_byte_mask(req_bmd)} << pos;
    assign mem_we  = (rstn && accept && req_we && !is_io) ? we_span[7:0] : 8'h00;

    assign crosses = ({1'b0, pos} + bmd_size(req_bmd)) > 4'd8;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) misalign_err <= 1'b0;
        else       misalign_err <= accept && !is_io && crosses;
    end

    // Shift register carrying alignment info alongside the memory read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LOAD_LATENCY; k++) pipe[k] <= '0;
        end else begin
            pipe[0].valid <= accept && !req_we && !is_io;
            pipe[0].pos   <= pos;
            pipe[0].bmd   <= req_bmd;
            for (int k = 1; k < LOAD_LATENCY; k++) pipe[k] <= pipe[k-1];
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < LOAD_LATENCY; k++) pipe_busy = pipe_busy | pipe[k].valid;
    end

    assign tail       = pipe[LOAD_LATENCY-1];
    assign ld_extract = (mem_ld_data >> {tail.pos, 3'b000}) & bmd_data_mask(tail.bmd);

    // I/O loads are only accepted with an empty pipeline, so the two result
    // sources never coincide.
    assign ld_valid = tail.valid || io_ld_valid;
    assign ld_data  = tail.valid  ? ld_extract :
                      io_ld_valid ? {56'd0, io_ld_data} : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            io_ld_valid <= 1'b0;
            io_ld_data  <= 8'h00;
        end else begin
            io_ld_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_io && !req_we) state <= IN_WAIT;
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        io_ld_valid <= 1'b1;
                        io_ld_data  <= in_data;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ack = (state == IN_WAIT) && in_valid;

    lsu_out_fifo #(
        .WIDTH (8),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept && req_we && is_io),
        .push_data (req_st_data[7:0]),
        .pop       (!fifo_empty && out_ack),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_req  = !fifo_empty;
    assign out_data = fifo_head;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit (LOAD_LATENCY = 2). Every cycle
// the outputs are compared with a transaction-level reference model built
// from queues; directed scenarios add fixed expected values on top, then a
// randomized phase exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] IOPTR = 32'hfffff000;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_we;
    addr_t       req_addr;
    bmd_t        req_bmd;
    reg_t        req_st_data;
    logic        req_ready;
    addr_t       mem_addr;
    logic [7:0]  mem_we;
    reg_t        mem_st_data;
    reg_t        mem_ld_data;
    logic        ld_valid;
    reg_t        ld_data;
    logic        misalign_err;
    logic        out_req;
    logic [7:0]  out_data;
    logic        out_ack;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ack;

    load_store_unit #(
        .LOAD_LATENCY    (LAT),
        .IO_FILE_POINTER (IOPTR),
        .OUT_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_bmd      (req_bmd),
        .req_st_data  (req_st_data),
        .req_ready    (req_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_st_data  (mem_st_data),
        .mem_ld_data  (mem_ld_data),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .misalign_err (misalign_err),
        .out_req      (out_req),
        .out_data     (out_data),
        .out_ack      (out_ack),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ack       (in_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        int          due;
        int          pos;
        int          size;
        logic [31:0] addr;
    } pendEntry_t;

    pendEntry_t  pendQ[$];
    logic [7:0]  fifoQ[$];
    logic        inWait;
    int          ioDue;
    logic [7:0]  ioData;
    logic        misPrev;
    int          cyc;
    logic [31:0] addrHist [4];

    logic        obsReady, obsLdValid, obsMis, obsInAck, obsOutReq;
    logic [7:0]  obsMemWe, obsOutData;
    logic [31:0] obsMemAddr;
    logic [63:0] obsStData, obsLdData;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
        end
    endtask

    // Deterministic memory contents, with the word at 0x200 fixed.
    function automatic logic [63:0] memWord(input logic [31:0] a);
        if (a == 32'h200) return 64'h8877665544332211;
        return {a * 32'h9E3779B1, a ^ 32'hDEADBEEF};
    endfunction

    function automatic logic [7:0] modelWe(input int pos, input int size);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) if (i >= pos && i < pos + size) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] modelStData(input logic [63:0] d, input int pos);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < 8; i++) if (i >= pos) r[8*i +: 8] = d[8*(i-pos) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] modelLd(input logic [63:0] w, input int pos, input int size);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < 8; i++) if (i < size && pos + i < 8) r[8*i +: 8] = w[8*(pos+i) +: 8];
        return r;
    endfunction

    task automatic modelClear();
        pendQ.delete();
        fifoQ.delete();
        inWait  = 1'b0;
        ioDue   = -1;
        misPrev = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model by the transactions of this cycle.
    task automatic applyStimulus(input logic v, input logic we, input logic [31:0] addr,
                                 input logic [1:0] bmd, input logic [63:0] data,
                                 input logic oack, input logic ival, input logic [7:0] idata);
        logic isIo, expReady, acc, expLdValid;
        logic [63:0] expLdData;
        int pos, size;
        @(negedge clk);
        req_valid   = v;
        req_we      = we;
        req_addr    = addr;
        req_bmd     = bmd_t'(bmd);
        req_st_data = data;
        out_ack     = oack;
        in_valid    = ival;
        in_data     = idata;
        mem_ld_data = memWord(addrHist[LAT-1]);
        #1;
        obsReady = req_ready;     obsMemWe  = mem_we;      obsMemAddr = mem_addr;
        obsStData = mem_st_data;  obsLdValid = ld_valid;   obsLdData  = ld_data;
        obsMis = misalign_err;    obsInAck  = in_ack;      obsOutReq  = out_req;
        obsOutData = out_data;

        isIo     = (addr == IOPTR);
        pos      = int'(addr[2:0]);
        size     = 1 << bmd;
        expReady = !(inWait || fifoQ.size() == DEPTH || (isIo && !we && pendQ.size() > 0));
        acc      = v && expReady;

        checkOutput("req_ready", obsReady, expReady);
        checkOutput("mem_we", obsMemWe, (acc && we && !isIo) ? modelWe(pos, size) : 8'h00);
        if (acc && !isIo) checkOutput("mem_addr", obsMemAddr, {addr[31:3], 3'b000});
        if (acc && we && !isIo) checkOutput("mem_st_data", obsStData, modelStData(data, pos));

        expLdValid = 1'b0;
        expLdData  = 64'd0;
        if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
            expLdValid = 1'b1;
            expLdData  = modelLd(memWord(pendQ[0].addr), pendQ[0].pos, pendQ[0].size);
        end else if (ioDue == cyc) begin
            expLdValid = 1'b1;
            expLdData  = {56'd0, ioData};
        end
        checkOutput("ld_valid", obsLdValid, expLdValid);
        if (expLdValid) checkOutput("ld_data", obsLdData, expLdData);
        checkOutput("misalign_err", obsMis, misPrev);
        checkOutput("in_ack", obsInAck, inWait && ival);
        checkOutput("out_req", obsOutReq, fifoQ.size() > 0);
        if (fifoQ.size() > 0) checkOutput("out_data", obsOutData, fifoQ[0]);

        if (oack && fifoQ.size() > 0) void'(fifoQ.pop_front());
        if (acc && we && isIo) fifoQ.push_back(data[7:0]);
        if (pendQ.size() > 0 && pendQ[0].due == cyc) void'(pendQ.pop_front());
        if (inWait && ival) begin
            ioDue  = cyc + 1;
            ioData = idata;
            inWait = 1'b0;
        end
        if (acc && !we && isIo) inWait = 1'b1;
        if (acc && !we && !isIo) pendQ.push_back('{cyc + LAT, pos, size, {addr[31:3], 3'b000}});
        misPrev = acc && !isIo && (pos + size > 8);

        for (int k = 3; k > 0; k--) addrHist[k] = addrHist[k-1];
        addrHist[0] = {addr[31:3], 3'b000};
        cyc++;
    endtask

    task automatic idleCycles(input int n, input logic oack, input logic ival);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 64'd0, oack, ival, 8'($urandom));
    endtask

    // Two-cycle reset pulse with a memory store presented the whole time.
    task automatic doReset();
        @(negedge clk);
        rstn        = 1'b0;
        req_valid   = 1'b1;
        req_we      = 1'b1;
        req_addr    = 32'h100;
        req_bmd     = BMD_64;
        req_st_data = 64'h1234;
        in_valid    = 1'b1;
        #1;
        checkOutput("rst_mem_we", mem_we, 8'h00);
        checkOutput("rst_out_req", out_req, 1'b0);
        checkOutput("rst_ld_valid", ld_valid, 1'b0);
        checkOutput("rst_ld_data", ld_data, 64'd0);
        checkOutput("rst_misalign", misalign_err, 1'b0);
        checkOutput("rst_in_ack", in_ack, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_mem_we2", mem_we, 8'h00);
        rstn      = 1'b1;
        req_valid = 1'b0;
        in_valid  = 1'b0;
        modelClear();
        cyc += 2;
    endtask

    initial begin
        logic [31:0] a;
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_bmd = BMD_8;
        req_st_data = '0; out_ack = 1'b0; in_valid = 1'b0; in_data = '0; mem_ld_data = '0;
        cyc = 0;
        for (int k = 0; k < 4; k++) addrHist[k] = 32'h0;
        modelClear();

        doReset();
        idleCycles(2, 1'b0, 1'b0);

        $display("[TB] store 0x105 BMD_16");
        applyStimulus(1'b1, 1'b1, 32'h105, 2'd1, 64'hABCD, 1'b0, 1'b0, 8'h00);
        checkOutput("st105_addr", obsMemAddr, 32'h100);
        checkOutput("st105_we", obsMemWe, 8'b0110_0000);
        checkOutput("st105_data", obsStData, 64'h00AB_CD00_0000_0000);
        idleCycles(1, 1'b0, 1'b0);
        checkOutput("idle_we", obsMemWe, 8'h00);

        $display("[TB] back-to-back loads");
        applyStimulus(1'b1, 1'b0, 32'h203, 2'd0, 64'd0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 32'h204, 2'd2, 64'd0, 1'b0, 1'b0, 8'h00);
        idleCycles(1, 1'b0, 1'b0);
        checkOutput("ld1_valid", obsLdValid, 1'b1);
        checkOutput("ld1_data", obsLdData, 64'h44);
        idleCycles(1, 1'b0, 1'b0);
        checkOutput("ld2_valid", obsLdValid, 1'b1);
        checkOutput("ld2_data", obsLdData, 64'h88776655);
        idleCycles(1, 1'b0, 1'b0);
        checkOutput("ld_done", obsLdValid, 1'b0);

        $display("[TB] IO stores filling the output FIFO");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, IOPTR, 2'd0, 64'h41 + 64'(i), 1'b0, 1'b0, 8'h00);
            checkOutput("io_st_ready", obsReady, 1'b1);
            checkOutput("io_st_we", obsMemWe, 8'h00);
        end
        applyStimulus(1'b1, 1'b1, IOPTR, 2'd0, 64'h45, 1'b0, 1'b0, 8'h00);
        checkOutput("fifo_full_ready", obsReady, 1'b0);
        applyStimulus(1'b1, 1'b1, IOPTR, 2'd0, 64'h45, 1'b1, 1'b0, 8'h00);
        checkOutput("pop_first", obsOutData, 8'h41);
        checkOutput("pop_cycle_ready", obsReady, 1'b0);
        applyStimulus(1'b1, 1'b1, IOPTR, 2'd0, 64'h45, 1'b0, 1'b0, 8'h00);
        checkOutput("fifth_ready", obsReady, 1'b1);
        checkOutput("second_head", obsOutData, 8'h42);
        idleCycles(6, 1'b1, 1'b0);
        checkOutput("fifo_drained", obsOutReq, 1'b0);

        $display("[TB] IO load");
        applyStimulus(1'b1, 1'b0, IOPTR, 2'd0, 64'd0, 1'b0, 1'b0, 8'h00);
        checkOutput("io_ld_ready", obsReady, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h300, 2'd3, 64'd0, 1'b0, 1'b0, 8'h00);
            checkOutput("in_wait_ready", obsReady, 1'b0);
            checkOutput("in_wait_ack", obsInAck, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 64'd0, 1'b0, 1'b1, 8'h5A);
        checkOutput("in_ack_pulse", obsInAck, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 64'd0, 1'b0, 1'b1, 8'h77);
        checkOutput("io_ld_valid", obsLdValid, 1'b1);
        checkOutput("io_ld_data", obsLdData, 64'h5A);
        checkOutput("in_ack_idle", obsInAck, 1'b0);

        $display("[TB] misaligned store and reset during waits");
        applyStimulus(1'b1, 1'b1, 32'h106, 2'd2, 64'h11223344, 1'b0, 1'b0, 8'h00);
        checkOutput("mis_we", obsMemWe, 8'b1100_0000);
        idleCycles(1, 1'b0, 1'b0);
        checkOutput("mis_pulse", obsMis, 1'b1);
        idleCycles(1, 1'b0, 1'b0);
        checkOutput("mis_once", obsMis, 1'b0);
        applyStimulus(1'b1, 1'b0, IOPTR, 2'd0, 64'd0, 1'b0, 1'b0, 8'h00);
        idleCycles(1, 1'b0, 1'b0);
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 64'd0, 1'b0, 1'b1, 8'hC3);
            checkOutput("post_rst_ld", obsLdValid, 1'b0);
            checkOutput("post_rst_ready", obsReady, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 32'h208, 2'd3, 64'd0, 1'b0, 1'b0, 8'h00);
        doReset();
        for (int i = 0; i < LAT + 1; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 64'd0, 1'b0, 1'b0, 8'h00);
            checkOutput("inflight_dropped", obsLdValid, 1'b0);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? IOPTR : {20'd0, 12'($urandom)};
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), a, 2'($urandom),
                          {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 2) == 0), 8'($urandom));
        end
        idleCycles(8, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
